// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
//   Direct-mapped, write-back, write-allocate cache controller with one 16-bit
//   word per line. It holds the pipeline with Stall while a request misses and
//   the dirty victim is written back and/or the new line is filled from the
//   backing memory.
//
// Parameters
//   IDX_W      cache index bits (2**IDX_W lines)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   Rd, Wr     pipeline read / write request (exactly one at a time)
//   Addr       byte address (bit 0 must be 0), index Addr[IDX_W:1]
//   DataIn     write data
//   DataOut    read data, non-zero only in the Done cycle of a read
//   Done       one-cycle completion pulse
//   Stall      hold request to the pipeline
//   CacheHit   with Done: the request finished without a miss
//   Err        one-cycle pulse on an illegal request
//   mem_req    backing-memory request, mem_wr gives the direction
//   mem_addr   backing-memory word address, mem_wdata write data
//   mem_ack    backing-memory completion pulse, mem_rdata read data
//   stall_cnt  saturating count of stalled cycles (only with MEM_STALL_CNT_EN)
//
// Build option
//   MEM_STALL_CNT_EN  adds the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module mem_stall_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        Err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 15 - IDX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_t;

  state_t            state;
  logic              req_rd;
  logic              req_wr;
  logic [14:0]       req_addr;   // latched Addr[15:1]
  logic [15:0]       req_data;
  logic              missed;     // a WB or FILL happened for this request

  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [15:0]       data_arr [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              legal;
  logic              illegal;

  assign idx     = req_addr[IDX_W-1:0];
  assign req_tag = req_addr[14:IDX_W];
  assign hit     = valid[idx] && (tag_arr[idx] == req_tag);
  assign legal   = (Rd ^ Wr) && !Addr[0];
  assign illegal = (Rd || Wr) && !legal;

  // Outputs are decoded from the registered state; only the IDLE-cycle Stall
  // and Err look at the live request, and those are gated by reset so every
  // output reads zero while rst is low.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    DataOut   = '0;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    Err       = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (rst) begin
          Stall = legal;
          Err   = illegal;
        end
      end
      COMPARE: begin
        if (hit) begin
          Done     = 1'b1;
          CacheHit = !missed;
          if (req_rd) DataOut = data_arr[idx];
        end else begin
          Stall = 1'b1;
        end
      end
      WB: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_arr[idx], idx, 1'b0};
        mem_wdata = data_arr[idx];
      end
      FILL: begin
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_addr, 1'b0};
      end
      default: ;
    endcase
  end

  // Control FSM plus per-line valid/dirty bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_rd   <= 1'b0;
      req_wr   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      missed   <= 1'b0;
      valid    <= '0;
      dirty    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      unique case (state)
        IDLE: begin
          if (legal) begin
            req_rd   <= Rd;
            req_wr   <= Wr;
            req_addr <= Addr[15:1];
            req_data <= DataIn;
            missed   <= 1'b0;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_wr) dirty[idx] <= 1'b1;
            state <= IDLE;
          end else begin
            missed <= 1'b1;
            state  <= (valid[idx] && dirty[idx]) ? WB : FILL;
          end
        end
        WB: begin
          if (mem_ack) state <= FILL;
        end
        FILL: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; a cleared valid bit makes their
  // contents irrelevant, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_wr) begin
      data_arr[idx] <= req_data;
    end else if (state == FILL && mem_ack) begin
      data_arr[idx] <= mem_rdata;
      tag_arr[idx]  <= req_tag;
    end
  end

`ifdef MEM_STALL_CNT_EN
  // Counts every edge taken with Stall high; holds at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (Stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  // Stall counter not built.
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stall_ctrl
//   Self-checking bench for mem_stall_ctrl. A reference model tracks the
//   architectural memory image (what a read must return), the backing-memory
//   image, and which address each cache index holds and whether it is dirty.
//   From that it predicts, per request, the cycle-by-cycle outputs: hit or
//   miss, write-back address/data, fill address, read data and CacheHit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stall_ctrl;

  localparam int IDX_W = 3;
  localparam int LINES = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        Err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rd        (Rd),
    .Wr        (Wr),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit),
    .Err       (Err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------------------------------------------------------- checking
  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=%h expected=%h", tag, txn_no, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=%b expected=%b", tag, txn_no, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [15:0] bmem [bit [15:0]];   // backing memory contents
  logic [15:0] arch [bit [15:0]];   // value a read of the address must return
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int unsigned m_tag   [LINES];
  int unsigned exp_stall = 0;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] bmem_rd(input logic [15:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [15:0] arch_rd(input logic [15:0] a);
    return arch.exists(a) ? arch[a] : bmem_rd(a);
  endfunction

  function automatic logic [15:0] line_addr(input int unsigned tag, input int i);
    return 16'((tag << (IDX_W + 1)) + (i * 2));
  endfunction

  // Reset loses any dirty data still in the cache.
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      if (m_valid[i] && m_dirty[i]) arch[line_addr(m_tag[i], i)] = bmem_rd(line_addr(m_tag[i], i));
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_stall = 0;
  endtask

  // Expected outputs of one post-acceptance cycle.
  typedef struct {
    bit          done;
    bit          stall;
    bit          req;
    bit          wr;
    bit          ack;
    bit          hit;
    bit          chk_dout;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    logic [15:0] rdata;
  } cyc_t;

  function automatic cyc_t mk(input bit done, input bit stall, input bit req, input bit wr,
                              input bit ack, input logic [15:0] addr, input logic [15:0] wdata);
    cyc_t c;
    c.done = done; c.stall = stall; c.req = req; c.wr = wr; c.ack = ack;
    c.hit = 1'b0; c.chk_dout = 1'b0;
    c.addr = addr; c.wdata = wdata; c.dout = 16'h0; c.rdata = 16'h0;
    return c;
  endfunction

  // One legal request; dly = cycles spent in each WB / FILL phase.
  task automatic txn(input bit rd, input logic [15:0] a, input logic [15:0] d, input int dly);
    cyc_t        q[$];
    cyc_t        c;
    int          i;
    int unsigned t;
    bit          hit;
    bit          wb;
    logic [15:0] wba;
    txn_no++;
    i   = int'((a >> 1) % LINES);
    t   = int'(a >> (IDX_W + 1));
    hit = m_valid[i] && (m_tag[i] == t);
    wb  = !hit && m_valid[i] && m_dirty[i];
    wba = line_addr(m_tag[i], i);
    if (!hit) begin
      q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0));
      if (wb)
        for (int k = 0; k < dly; k++)
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, k == dly - 1, wba, arch_rd(wba)));
      for (int k = 0; k < dly; k++) begin
        c = mk(1'b0, 1'b1, 1'b1, 1'b0, k == dly - 1, a, 16'h0);
        c.rdata = bmem_rd(a);
        q.push_back(c);
      end
    end
    c = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    c.hit = hit;
    c.chk_dout = rd;
    c.dout = rd ? arch_rd(a) : 16'h0;
    q.push_back(c);

    // Acceptance cycle; a stray mem_ack here must be ignored.
    Rd = rd; Wr = !rd; Addr = a; DataIn = d;
    mem_ack = ($urandom_range(2) == 0); mem_rdata = 16'($urandom);
    @(negedge clk);
    check1("accept_stall", Stall, 1'b1);
    check1("accept_err", Err, 1'b0);
    check1("accept_done", Done, 1'b0);
    check1("accept_mem_req", mem_req, 1'b0);
    exp_stall++;
    @(posedge clk); #1;

    foreach (q[n]) begin
      // Pipeline inputs wiggle while busy; only the latched copies count.
      Rd = 1'($urandom); Wr = 1'($urandom); Addr = 16'($urandom); DataIn = 16'($urandom);
      if (q[n].ack) begin
        mem_ack = 1'b1;
        mem_rdata = (q[n].req && !q[n].wr) ? q[n].rdata : 16'($urandom);
      end else if (!q[n].req) begin
        mem_ack = ($urandom_range(2) == 0);
        mem_rdata = 16'($urandom);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      check1("done", Done, q[n].done);
      check1("stall", Stall, q[n].stall);
      check1("err", Err, 1'b0);
      check1("mem_req", mem_req, q[n].req);
      check1("mem_wr", mem_wr, q[n].wr);
      check16("mem_addr", mem_addr, q[n].addr);
      check16("mem_wdata", mem_wdata, q[n].wdata);
      check1("cache_hit", CacheHit, q[n].done && q[n].hit);
      if (!q[n].done || q[n].chk_dout) check16("data_out", DataOut, q[n].dout);
      if (q[n].stall) exp_stall++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0;
`ifdef MEM_STALL_CNT_EN
    check16("stall_cnt", stall_cnt, 16'(exp_stall));
`endif

    if (wb) bmem[wba] = arch_rd(wba);
    if (!hit) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_dirty[i] = 1'b0;
    end
    if (!rd) begin
      arch[a]    = d;
      m_dirty[i] = 1'b1;
    end
  endtask

  // Illegal request: Err for one cycle, nothing accepted.
  task automatic illegal(input bit rd, input bit wr, input logic [15:0] a);
    txn_no++;
    Rd = rd; Wr = wr; Addr = a; DataIn = 16'($urandom);
    @(negedge clk);
    check1("illegal_err", Err, 1'b1);
    check1("illegal_stall", Stall, 1'b0);
    check1("illegal_done", Done, 1'b0);
    check1("illegal_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0;
    @(negedge clk);
    check1("after_illegal_err", Err, 1'b0);
    check1("after_illegal_stall", Stall, 1'b0);
    check1("after_illegal_done", Done, 1'b0);
    check1("after_illegal_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check16({tag, "_data_out"}, DataOut, 16'h0);
    check1({tag, "_done"}, Done, 1'b0);
    check1({tag, "_stall"}, Stall, 1'b0);
    check1({tag, "_cache_hit"}, CacheHit, 1'b0);
    check1({tag, "_err"}, Err, 1'b0);
    check1({tag, "_mem_req"}, mem_req, 1'b0);
    check1({tag, "_mem_wr"}, mem_wr, 1'b0);
    check16({tag, "_mem_addr"}, mem_addr, 16'h0);
    check16({tag, "_mem_wdata"}, mem_wdata, 16'h0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] a;
    int unsigned tg;

    // Reset with an illegal request on the inputs: everything must read 0.
    rst = 1'b0; Rd = 1'b1; Wr = 1'b1; Addr = 16'h0011;
    #12;
    check_all_zero("reset");
`ifdef MEM_STALL_CNT_EN
    check16("reset_stall_cnt", stall_cnt, 16'h0);
`endif
    Rd = 1'b0; Wr = 1'b0; Addr = 16'h0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // First read of 0x0010 misses and fills 0xBEEF.
    bmem[16'h0010] = 16'hBEEF;
    txn(1'b1, 16'h0010, 16'h0, 1);
    // Repeat read hits with no memory traffic.
    txn(1'b1, 16'h0010, 16'h0, 2);
    // Write hit, then a conflicting read forces write-back of 0x1234.
    txn(1'b0, 16'h0010, 16'h1234, 1);
    txn(1'b1, 16'h0110, 16'h0, 2);

    // Illegal requests leave the state untouched.
    illegal(1'b1, 1'b1, 16'h0010);
    illegal(1'b1, 1'b0, 16'h0003);
    illegal(1'b0, 1'b1, 16'h0105);
    txn(1'b1, 16'h0110, 16'h0, 1);

    // Reset during FILL abandons the transfer.
    txn_no++;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010;
    @(posedge clk); #1;
    Rd = 1'b0; Addr = 16'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check1("fill_mem_req", mem_req, 1'b1);
    check16("fill_mem_addr", mem_addr, 16'h0010);
    #1 rst = 1'b0;
    #1;
    check1("rst_fill_mem_req", mem_req, 1'b0);
    check16("rst_fill_mem_addr", mem_addr, 16'h0);
    check1("rst_fill_stall", Stall, 1'b0);
    check1("rst_fill_done", Done, 1'b0);
    model_reset();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_ack = 1'b0; rst = 1'b1;
    @(negedge clk);
    check1("post_rst_done", Done, 1'b0);
    check1("post_rst_mem_req", mem_req, 1'b0);
    check1("post_rst_stall", Stall, 1'b0);
    @(posedge clk); #1;
    // Both previously cached addresses now miss.
    txn(1'b1, 16'h0010, 16'h0, 1);
    txn(1'b1, 16'h0110, 16'h0, 1);

    // Clean miss with four FILL cycles from a fresh reset: six stalled edges.
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    txn(1'b1, 16'h0020, 16'h0, 4);
`ifdef MEM_STALL_CNT_EN
    check16("stall_cnt_six", stall_cnt, 16'd6);
`endif

    // Randomized traffic over a small set of tags to mix hits, clean and
    // dirty misses.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(9) == 0) begin
        if ($urandom_range(1) == 0) illegal(1'b1, 1'b1, 16'($urandom) & 16'hFFFE);
        else illegal(1'($urandom), 1'b1, 16'($urandom) | 16'h0001);
      end else begin
        case ($urandom_range(3))
          0:       tg = 0;
          1:       tg = 1;
          2:       tg = 12'h5A5;
          default: tg = 12'hFFF;
        endcase
        a = line_addr(tg, int'($urandom_range(LINES - 1)));
        txn(1'($urandom), a, 16'($urandom), 1 + int'($urandom_range(2)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter IDX_W, default 3, meaning cache index bits (2**IDX_W direct-mapped lines, one 16-bit word each).
REQ-002 clk  input  1  single system clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 Rd  input  1  pipeline read request.
REQ-005 Wr  input  1  pipeline write request.
REQ-006 Addr  input  16  byte address: Addr[0] must be 0, index Addr[IDX_W:1], tag Addr[15:IDX_W+1].
REQ-007 DataIn  input  16  write data.
REQ-008 DataOut  output  16  read data, valid only while Done=1.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 Stall  output  1  mem_stall to the pipeline stall unit.
REQ-011 CacheHit  output  1  valid with Done: request completed with no miss.
REQ-012 Err  output  1  one-cycle pulse on an illegal request.
REQ-013 mem_req / mem_wr  output  1 / 1  backing-memory request and direction.
REQ-014 mem_addr / mem_wdata  output  16 / 16  backing-memory address and write data.
REQ-015 mem_ack / mem_rdata  input  1 / 16  backing-memory completion pulse and read data.
REQ-016 stall_cnt  output  16  stall-cycle counter; present only under MEM_STALL_CNT_EN.

Function
REQ-017 FSM states: IDLE, COMPARE, WB, FILL. Per-line state: valid, dirty, tag, data.
REQ-018 IDLE with exactly one of Rd/Wr and Addr[0]=0: latch Rd, Wr, Addr and DataIn, then go to COMPARE. Stall=1 combinationally in that cycle.
REQ-019 IDLE with Rd=Wr=1, or with Addr[0]=1: Err=1 for that cycle, request ignored, Stall=0, state unchanged.
REQ-020 COMPARE, hit (valid and tag match): Done=1, Stall=0, return to IDLE.
  - Read hit: DataOut = line data.
  - Write hit: line data = latched DataIn, dirty=1.
  - Hit latency is 1 cycle after acceptance.
REQ-021 COMPARE, miss: go to WB if the line is valid and dirty, otherwise go to FILL. Stall=1.
REQ-022 WB: mem_req=1, mem_wr=1, mem_addr={old tag, index, 1'b0}, mem_wdata=line data; on mem_ack go to FILL.
REQ-023 FILL: mem_req=1, mem_wr=0, mem_addr={latched Addr[15:1], 1'b0}; on mem_ack install mem_rdata, set valid=1, dirty=0, load the new tag, then go to COMPARE.
REQ-024 Stall=1 in every cycle of WB, FILL and miss-COMPARE; Stall=0 when Done=1 and in IDLE with no valid request.
REQ-025 CacheHit=1 with Done only if no WB or FILL state occurred for this request; otherwise 0.
REQ-026 mem_ack in IDLE or COMPARE is ignored.
REQ-027 Rd, Wr, Addr and DataIn are ignored while state is not IDLE; only the latched copies are used.
REQ-028 Outputs Done, Err, CacheHit, mem_req and mem_wr are 0 whenever not asserted by the rules above. DataOut, mem_addr and mem_wdata are 0 when not valid.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE; all valid and dirty bits 0; Done, Stall, CacheHit, Err, mem_req and mem_wr 0; DataOut, mem_addr and mem_wdata 0x0000; stall_cnt 0.
REQ-030 Reset during WB or FILL abandons the transfer: mem_req drops immediately and the request is lost with no Done.
REQ-031 Tag and data arrays need not be reset.

Configuration
REQ-032 Macro MEM_STALL_CNT_EN defined: stall_cnt increments by 1 on every rising edge with Stall=1, saturates at 0xFFFF, and clears only on reset.
REQ-033 Macro MEM_STALL_CNT_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-034 After reset, Rd at Addr=0x0010 -> Stall=1, FILL with mem_addr=0x0010; mem_ack with mem_rdata=0xBEEF -> next COMPARE gives Done=1, DataOut=0xBEEF, CacheHit=0.
REQ-035 Repeat the read of 0x0010 -> Done one cycle after acceptance, DataOut=0xBEEF, CacheHit=1, mem_req stays 0.
REQ-036 Wr 0x1234 to 0x0010 (hit), then Rd 0x0110 (same index, new tag) -> WB with mem_addr=0x0010 and mem_wdata=0x1234, then FILL with mem_addr=0x0110.
REQ-037 Rd=Wr=1, or Rd with Addr=0x0003 -> Err pulses for 1 cycle, Stall=0, no state change.
REQ-038 rst=0 during FILL -> mem_req=0 immediately and no Done; the next Rd of 0x0010 misses.
REQ-039 With MEM_STALL_CNT_EN defined, a miss with mem_ack after 4 FILL cycles -> stall_cnt=6 (accept + miss-COMPARE + 4 FILL).
